// File: rtl/alu_seq_unit_if.sv
// alu_seq_unit_if: bundles the operand-step, request/handshake and result
// signals of alu_seq_unit.
//   master : drives evt, dir, op, start; observes busy, done, a, b, result, flags
//   slave  : the ALU side (inverse directions)
// Parameter WIDTH matches the ALU operand width; result is 2*WIDTH bits.
interface alu_seq_unit_if #(
  parameter int unsigned WIDTH = 4
);
  logic [1:0]         evt;
  logic [1:0]         dir;
  logic [2:0]         op;
  logic               start;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [2*WIDTH-1:0] result;
  logic               co;
  logic               ovf;
  logic               zero;

  modport master (
    output evt, dir, op, start,
    input  busy, done, a, b, result, co, ovf, zero
  );

  modport slave (
    input  evt, dir, op, start,
    output busy, done, a, b, result, co, ovf, zero
  );
endinterface

// File: rtl/alu_seq_unit.sv
// alu_seq_unit: clocked ALU with two event-stepped operand registers,
// single-cycle ADD/SUB/AND/OR/XOR/SLT and a multi-cycle shift-add multiply.
// Ports:
//   clk    : system clock
//   rst_n  : synchronous active-low reset
//   bus    : alu_seq_unit_if.slave (evt/dir operand steps, op/start request,
//            busy/done handshake, a/b operands, result/co/ovf/zero)
// Build option: define ALU_MUL_EN to compile in the multiplier (opcode 110).
// Without it opcode 110 behaves as reserved and busy is tied low.
module alu_seq_unit #(
  parameter int unsigned WIDTH = 4
) (
  input logic          clk,
  input logic          rst_n,
  alu_seq_unit_if.slave bus
);
  localparam int unsigned RW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_MUL, OP_RSV
  } op_t;

  typedef enum logic {IDLE, MUL} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_q, b_q;
  logic [RW-1:0]    result_q;
  logic             co_q, ovf_q, zero_q, done_q;

  logic             accept;
  logic             mul_start;
  logic             mul_last;
  logic [RW-1:0]    mul_res;

  logic [WIDTH:0]   sum, diff;
  logic [RW-1:0]    alu_res;
  logic             alu_co, alu_ovf;

  assign accept = (state == IDLE) && bus.start;

`ifdef ALU_MUL_EN
  logic [RW-1:0]    mcand, acc;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    cnt;

  assign mul_start = accept && (op_t'(bus.op) == OP_MUL);
  assign mul_last  = (state == MUL) && (cnt == CW'(WIDTH - 1));
  // Sum including the current iteration, so the final edge can write it directly.
  assign mul_res   = mplier[0] ? acc + mcand : acc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (mul_start) begin
      mcand  <= {{WIDTH{1'b0}}, a_q};
      mplier <= b_q;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == MUL) begin
      acc    <= mul_res;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end
`else
  assign mul_start = 1'b0;
  assign mul_last  = 1'b0;
  assign mul_res   = '0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (mul_start) state_next = MUL;
      MUL:     if (mul_last)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output / datapath combinational logic
  always_comb begin
    sum     = {1'b0, a_q} + {1'b0, b_q};
    diff    = {1'b0, a_q} - {1'b0, b_q};
    alu_res = '0;
    alu_co  = 1'b0;
    alu_ovf = 1'b0;
    case (op_t'(bus.op))
      OP_ADD: begin
        alu_res = {{WIDTH{1'b0}}, sum[WIDTH-1:0]};
        alu_co  = sum[WIDTH];
        alu_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = {{WIDTH{1'b0}}, diff[WIDTH-1:0]};
        alu_co  = diff[WIDTH];
        alu_ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND:  alu_res = {{WIDTH{1'b0}}, a_q & b_q};
      OP_OR:   alu_res = {{WIDTH{1'b0}}, a_q | b_q};
      OP_XOR:  alu_res = {{WIDTH{1'b0}}, a_q ^ b_q};
      OP_SLT:  alu_res = {{(RW-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      default: alu_res = '0;
    endcase
`ifdef ALU_MUL_EN
    bus.busy = (state == MUL);
`else
    bus.busy = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      co_q     <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      if (bus.evt[0]) a_q <= bus.dir[0] ? a_q - 1'b1 : a_q + 1'b1;
      if (bus.evt[1]) b_q <= bus.dir[1] ? b_q - 1'b1 : b_q + 1'b1;
      done_q <= 1'b0;
      if (accept && !mul_start) begin
        result_q <= alu_res;
        co_q     <= alu_co;
        ovf_q    <= alu_ovf;
        zero_q   <= (alu_res == '0);
        done_q   <= 1'b1;
      end else if (mul_last) begin
        result_q <= mul_res;
        co_q     <= |mul_res[RW-1:WIDTH];
        ovf_q    <= 1'b0;
        zero_q   <= (mul_res == '0);
        done_q   <= 1'b1;
      end
    end
  end

  assign bus.a      = a_q;
  assign bus.b      = b_q;
  assign bus.result = result_q;
  assign bus.co     = co_q;
  assign bus.ovf    = ovf_q;
  assign bus.zero   = zero_q;
  assign bus.done   = done_q;
endmodule

// File: tb/tb_alu_seq_unit.sv
// tb_alu_seq_unit: directed and randomized stimulus for alu_seq_unit, checked
// against an arithmetic reference model. Honours ALU_MUL_EN like the design.
module tb_alu_seq_unit;
  localparam int W = 4;
  localparam int M = 1 << W;
`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  alu_seq_unit_if #(.WIDTH(W)) bus ();

  alu_seq_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  int         ma, mb, mcnt;
  int         mres, pres;
  bit         mco, movf, mzero, mbusy, mdone, pco;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sgn(input int v);
    return (v >= M / 2) ? v - M : v;
  endfunction

  function automatic void alu_ref(input int op, input int a, input int b,
                                  output int r, output bit c, output bit o);
    int s;
    r = 0; c = 0; o = 0;
    case (op)
      0: begin s = a + b; r = s % M; c = (s >= M);
               s = sgn(a) + sgn(b); o = (s > M / 2 - 1) || (s < -M / 2); end
      1: begin r = (a - b + M) % M; c = (a < b);
               s = sgn(a) - sgn(b); o = (s > M / 2 - 1) || (s < -M / 2); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = (sgn(a) < sgn(b)) ? 1 : 0;
      6: if (MUL_EN) begin r = a * b; c = ((a * b) / M) != 0; end
      default: r = 0;
    endcase
  endfunction

  task automatic model_edge();
    int r; bit c, o;
    if (!rst_n) begin
      ma = 0; mb = 0; mres = 0; mco = 0; movf = 0; mzero = 0;
      mbusy = 0; mdone = 0; mcnt = 0;
      return;
    end
    mdone = 0;
    if (mbusy) begin
      mcnt--;
      if (mcnt == 0) begin
        mbusy = 0; mres = pres; mco = pco; movf = 0; mzero = (pres == 0); mdone = 1;
      end
    end else if (bus.start) begin
      alu_ref(int'(bus.op), ma, mb, r, c, o);
      if (bus.op == 3'd6 && MUL_EN) begin
        mbusy = 1; mcnt = W; pres = r; pco = c;
      end else begin
        mres = r; mco = c; movf = o; mzero = (r == 0); mdone = 1;
      end
    end
    if (bus.evt[0]) ma = bus.dir[0] ? (ma + M - 1) % M : (ma + 1) % M;
    if (bus.evt[1]) mb = bus.dir[1] ? (mb + M - 1) % M : (mb + 1) % M;
  endtask

  // One clock edge: update model, then compare every output 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check("a", 32'(bus.a), 32'(ma));
    check("b", 32'(bus.b), 32'(mb));
    check("busy", 32'(bus.busy), 32'(mbusy));
    check("done", 32'(bus.done), 32'(mdone));
    check("result", 32'(bus.result), 32'(mres));
    check("co", 32'(bus.co), 32'(mco));
    check("ovf", 32'(bus.ovf), 32'(movf));
    check("zero", 32'(bus.zero), 32'(mzero));
  endtask

  task automatic idle_inputs();
    bus.evt = 2'b00; bus.dir = 2'b00; bus.start = 1'b0; bus.op = 3'd0;
  endtask

  // Step the operands upward until the model holds the requested values.
  task automatic set_ab(input int x, input int y);
    for (int i = 0; i < 2 * M && (ma != x || mb != y); i++) begin
      bus.evt = {mb != y, ma != x};
      bus.dir = 2'b00;
      cyc();
    end
    idle_inputs();
    check("set_a", 32'(bus.a), 32'(x));
    check("set_b", 32'(bus.b), 32'(y));
  endtask

  task automatic run_op(input logic [2:0] op);
    bus.op = op; bus.start = 1'b1;
    cyc();
    idle_inputs();
  endtask

  initial begin
    checks = 0; errors = 0;
    ma = 0; mb = 0; mres = 0; pres = 0; mcnt = 0;
    mco = 0; movf = 0; mzero = 0; mbusy = 0; mdone = 0; pco = 0;
    idle_inputs();
    rst_n = 1'b0;
    cyc(); cyc();
    check("rst_zero", 32'(bus.zero), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    rst_n = 1'b1;
    cyc();

    // ADD with carry and signed overflow
    set_ab(9, 8);
    run_op(3'd0);
    check("add_res", 32'(bus.result), 32'h01);
    check("add_co", 32'(bus.co), 32'd1);
    check("add_ovf", 32'(bus.ovf), 32'd1);
    check("add_done", 32'(bus.done), 32'd1);
    cyc();
    check("add_done_pulse", 32'(bus.done), 32'd0);

    // SUB with borrow, then equal operands
    set_ab(3, 5);
    run_op(3'd1);
    check("sub_res", 32'(bus.result), 32'h0E);
    check("sub_co", 32'(bus.co), 32'd1);
    check("sub_ovf", 32'(bus.ovf), 32'd0);
    set_ab(5, 5);
    run_op(3'd1);
    check("sub_zero", 32'(bus.zero), 32'd1);
    check("sub_eq_co", 32'(bus.co), 32'd0);

    // 15*15
    set_ab(15, 15);
    run_op(3'd6);
`ifdef ALU_MUL_EN
    for (int i = 0; i < W - 1; i++) begin
      check("mul_busy", 32'(bus.busy), 32'd1);
      cyc();
    end
    check("mul_busy_last", 32'(bus.busy), 32'd1);
    cyc();
    check("mul_res", 32'(bus.result), 32'hE1);
    check("mul_co", 32'(bus.co), 32'd1);
    check("mul_done", 32'(bus.done), 32'd1);
    check("mul_busy_clr", 32'(bus.busy), 32'd0);
    cyc();
    check("mul_done_pulse", 32'(bus.done), 32'd0);
`else
    check("nomul_res", 32'(bus.result), 32'd0);
    check("nomul_zero", 32'(bus.zero), 32'd1);
    check("nomul_done", 32'(bus.done), 32'd1);
    cyc();
`endif

    // Wrap in both directions
    set_ab(15, 0);
    bus.evt = 2'b11; bus.dir = 2'b10;
    cyc();
    idle_inputs();
    check("wrap_a", 32'(bus.a), 32'd0);
    check("wrap_b", 32'(bus.b), 32'd15);

    // Start and events on the same edge use pre-event operands
    set_ab(3, 4);
    bus.evt = 2'b11; bus.dir = 2'b00;
    run_op(3'd0);
    check("same_edge_res", 32'(bus.result), 32'd7);
    check("same_edge_a", 32'(bus.a), 32'd4);

    // Start during a multiply is dropped; events still step
    set_ab(7, 6);
    run_op(3'd6);
    bus.op = 3'd0; bus.start = 1'b1; bus.evt = 2'b01; bus.dir = 2'b00;
    cyc();
    idle_inputs();
`ifdef ALU_MUL_EN
    for (int i = 0; i < W - 1; i++) cyc();
    check("mul76_res", 32'(bus.result), 32'h2A);
    check("mul76_a", 32'(bus.a), 32'd8);
`endif
    cyc();

    // Reset in the middle of a multiply
    set_ab(3, 3);
    run_op(3'd6);
    cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    check("rst_mid_result", 32'(bus.result), 32'd0);
    for (int i = 0; i < W + 1; i++) cyc();

    // Randomized traffic, including back-to-back starts
    for (int i = 0; i < 800; i++) begin
      bus.evt   = 2'($urandom);
      bus.dir   = 2'($urandom);
      bus.op    = 3'($urandom);
      bus.start = ($urandom_range(0, 2) == 0);
      rst_n     = ($urandom_range(0, 99) != 0);
      cyc();
    end
    idle_inputs();
    rst_n = 1'b1;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
